// File: rtl/led_matrix_if.sv
// Pin-level bundle between the LED matrix controller and its board/bench.
// UART, control inputs, matrix drives and status outputs travel together.
interface led_matrix_if #(
    parameter int unsigned MATRIX_SIZE = 8
);
    logic                   uart_rx;
    logic                   uart_tx;
    logic [1:0]             roll_ctrl;
    logic                   bright_ctrl;
    logic [MATRIX_SIZE-1:0] row_sel;
    logic [MATRIX_SIZE-1:0] col_r;
    logic [MATRIX_SIZE-1:0] col_g;
    logic [MATRIX_SIZE-1:0] col_b;
    logic [1:0]             bright_state;
    logic [1:0]             led_state;

    modport master (
        output uart_rx, roll_ctrl, bright_ctrl,
        input  uart_tx, row_sel, col_r, col_g, col_b, bright_state, led_state
    );

    modport slave (
        input  uart_rx, roll_ctrl, bright_ctrl,
        output uart_tx, row_sel, col_r, col_g, col_b, bright_state, led_state
    );
endinterface

// File: rtl/led_matrix_top.sv
// 8x8 RGB332 LED matrix controller: UART frame loader with echo, row scan,
// PWM brightness stepped by a debounced button, and horizontal scrolling.
module led_matrix_top #(
    parameter int unsigned MATRIX_SIZE     = 8,
    parameter int unsigned CLK_HZ          = 100000000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned ROW_CYCLES      = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned SCROLL_CYCLES   = 100000
) (
    input logic        clk,
    input logic        rst_n,
    led_matrix_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned DEPTH = MATRIX_SIZE * MATRIX_SIZE;
    localparam int unsigned CW    = $clog2(MATRIX_SIZE);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned BCW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW    = $clog2(ROW_CYCLES);
    localparam int unsigned SW    = $clog2(SCROLL_CYCLES);
    localparam int unsigned DW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [BCW-1:0] BIT_M1  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_M1 = BCW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e      rx_state_q, rx_state_d;
    logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic           rx_valid;
    logic           rx_meta_q, rx_sync_q, rx_prev_q;

    logic [9:0]     tx_shift_q;
    logic [3:0]     tx_left_q;
    logic [BCW-1:0] tx_cnt_q;
    logic [7:0]     hold_q;
    logic           hold_full_q;
    logic           tx_busy;

    logic [7:0]     fb_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;

    logic [TW-1:0]  t_q;
    logic [CW-1:0]  row_q, offset_q, phys_col;
    logic [AW-1:0]  read_addr;
    logic [7:0]     pixel;
    logic           started_q;
    logic [SW-1:0]  scroll_cnt_q;
    logic [MATRIX_SIZE-1:0] line_r_q, line_g_q, line_b_q;
    logic [TW:0]    win_end;
    logic           active;
    logic [1:0]     mode;

    logic           btn_meta_q, btn_sync_q, btn_stable_q;
    logic [DW-1:0]  db_cnt_q;
    logic [1:0]     bright_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_valid   = rx_sync_q;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= bus.uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    assign tx_busy = (tx_left_q != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q  <= '1;
            tx_left_q   <= '0;
            tx_cnt_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (!tx_busy && hold_full_q) begin
                tx_shift_q  <= {1'b1, hold_q, 1'b0};
                tx_left_q   <= 4'd10;
                tx_cnt_q    <= '0;
                hold_full_q <= 1'b0;
            end else if (tx_busy) begin
                if (tx_cnt_q == BIT_M1) begin
                    tx_cnt_q   <= '0;
                    tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    tx_left_q  <= tx_left_q - 1'b1;
                end else begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                end
            end
            // The holding slot frees in the same cycle it is handed to the shifter.
            if (rx_valid && (!hold_full_q || !tx_busy)) begin
                hold_q      <= rx_shift_q;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign bus.uart_tx = tx_busy ? tx_shift_q[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fb_q[i] <= '0;
            wr_ptr_q <= '0;
        end else if (rx_valid) begin
            fb_q[wr_ptr_q] <= rx_shift_q;
            wr_ptr_q       <= wr_ptr_q + 1'b1;
        end
    end

    assign mode      = (bus.roll_ctrl == 2'b11) ? 2'b00 : bus.roll_ctrl;
    assign phys_col  = t_q[CW-1:0] + offset_q;
    assign read_addr = {row_q, phys_col};
    assign pixel     = fb_q[read_addr];
    assign win_end   = (TW+1)'((32'(bright_q) + 32'd1) * ROW_CYCLES / 32'd4);
    assign active    = (t_q >= TW'(MATRIX_SIZE)) && ({1'b0, t_q} < win_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q          <= '0;
            row_q        <= '0;
            started_q    <= 1'b0;
            offset_q     <= '0;
            scroll_cnt_q <= '0;
            line_r_q     <= '0;
            line_g_q     <= '0;
            line_b_q     <= '0;
        end else begin
            started_q <= 1'b1;
            if (t_q == TW'(ROW_CYCLES - 1)) begin
                t_q   <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                t_q <= t_q + 1'b1;
            end
            if (t_q < TW'(MATRIX_SIZE)) begin
                line_r_q[t_q[CW-1:0]] <= |pixel[7:5];
                line_g_q[t_q[CW-1:0]] <= |pixel[4:2];
                line_b_q[t_q[CW-1:0]] <= |pixel[1:0];
            end
            if (scroll_cnt_q == SW'(SCROLL_CYCLES - 1)) begin
                scroll_cnt_q <= '0;
                if (mode == 2'b10) offset_q <= offset_q + 1'b1;
                else if (mode == 2'b01) offset_q <= offset_q - 1'b1;
            end else begin
                scroll_cnt_q <= scroll_cnt_q + 1'b1;
            end
        end
    end

    assign bus.row_sel   = started_q ? (MATRIX_SIZE'(1) << row_q) : '0;
    assign bus.col_r     = active ? line_r_q : '0;
    assign bus.col_g     = active ? line_g_q : '0;
    assign bus.col_b     = active ? line_b_q : '0;
    assign bus.led_state = mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q   <= 1'b1;
            btn_sync_q   <= 1'b1;
            btn_stable_q <= 1'b1;
            db_cnt_q     <= '0;
            bright_q     <= 2'b11;
        end else begin
            btn_meta_q <= bus.bright_ctrl;
            btn_sync_q <= btn_meta_q;
            if (btn_sync_q == btn_stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_q     <= '0;
                btn_stable_q <= btn_sync_q;
                if (!btn_sync_q) bright_q <= bright_q + 1'b1;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign bus.bright_state = bright_q;
endmodule

// File: tb/tb_led_matrix_top.sv
// Bench for led_matrix_top with shortened timing parameters; checks the
// echo stream, scanned column patterns, brightness and scroll against a model.
module tb_led_matrix_top;
    localparam int unsigned CPB = 16;
    localparam int unsigned ROW = 64;
    localparam int unsigned DEB = 20;
    localparam int unsigned SCR = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_matrix_if #(.MATRIX_SIZE(8)) bus ();

    led_matrix_top #(
        .MATRIX_SIZE(8),
        .CLK_HZ(100000000),
        .BAUD(6250000),
        .ROW_CYCLES(ROW),
        .DEBOUNCE_CYCLES(DEB),
        .SCROLL_CYCLES(SCR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] frame_m [64];
    int wr_m = 0;
    logic [7:0] exp_echo [$];
    logic [7:0] got_echo [$];

    // Scroll-offset model: one step of the current mode every SCR cycles.
    int m_off, scyc, since_tick;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_off <= 0;
            scyc <= 0;
            since_tick <= 0;
        end else if (scyc + 1 == SCR) begin
            scyc <= 0;
            since_tick <= 0;
            if (bus.roll_ctrl == 2'b10) m_off <= (m_off + 1) % 8;
            else if (bus.roll_ctrl == 2'b01) m_off <= (m_off + 7) % 8;
        end else begin
            scyc <= scyc + 1;
            since_tick <= since_tick + 1;
        end
    end

    initial begin
        forever begin
            logic [7:0] b;
            @(negedge bus.uart_tx);
            if (rst_n) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.uart_tx;
                end
                repeat (CPB) @(negedge clk);
                got_echo.push_back(b);
            end
        end
    end

    function automatic logic [7:0] exp_cols(input int row, input int off, input int ch);
        logic [7:0] v;
        logic [7:0] px;
        for (int c = 0; c < 8; c++) begin
            px = frame_m[row * 8 + (c + off) % 8];
            if (ch == 0) v[c] = |px[7:5];
            else if (ch == 1) v[c] = |px[4:2];
            else v[c] = |px[1:0];
        end
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uart_rx = stop;
        repeat (CPB) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        frame_m[wr_m] = b;
        wr_m = (wr_m + 1) % 64;
        exp_echo.push_back(b);
    endtask

    task automatic check_echo(input string name);
        logic [7:0] e, g;
        for (int i = 0; i < 40 * CPB && got_echo.size() < exp_echo.size(); i++) @(negedge clk);
        repeat (12 * CPB) @(negedge clk);
        n_cmp++;
        if (got_echo.size() !== exp_echo.size()) begin
            n_err++;
            $display("FAIL %s echo_count got %0d want %0d", name, got_echo.size(),
                     exp_echo.size());
        end
        while (got_echo.size() > 0 && exp_echo.size() > 0) begin
            e = exp_echo.pop_front();
            g = got_echo.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s echo_byte got %02h want %02h", name, g, e);
            end
        end
        exp_echo.delete();
        got_echo.delete();
    endtask

    task automatic wait_row(input int r, output bit ok);
        logic [7:0] target;
        int i;
        target = 8'(1 << r);
        i = 0;
        while (bus.row_sel === target && i < 20 * ROW) begin
            @(negedge clk);
            i++;
        end
        i = 0;
        while (bus.row_sel !== target && i < 20 * ROW) begin
            @(negedge clk);
            i++;
        end
        ok = (bus.row_sel === target);
    endtask

    task automatic check_rows(input string name);
        bit ok, done;
        logic [7:0] er, eg, eb;
        for (int r = 0; r < 8; r++) begin
            done = 1'b0;
            for (int tr = 0; tr < 4 && !done; tr++) begin
                wait_row(r, ok);
                if (ok) begin
                    repeat (10) @(negedge clk);
                    if (since_tick > int'(ROW) + 16) begin
                        done = 1'b1;
                        er = exp_cols(r, m_off, 0);
                        eg = exp_cols(r, m_off, 1);
                        eb = exp_cols(r, m_off, 2);
                        n_cmp += 3;
                        if (bus.col_r !== er) begin
                            n_err++;
                            $display("FAIL %s row%0d col_r got %02h want %02h", name, r,
                                     bus.col_r, er);
                        end
                        if (bus.col_g !== eg) begin
                            n_err++;
                            $display("FAIL %s row%0d col_g got %02h want %02h", name, r,
                                     bus.col_g, eg);
                        end
                        if (bus.col_b !== eb) begin
                            n_err++;
                            $display("FAIL %s row%0d col_b got %02h want %02h", name, r,
                                     bus.col_b, eb);
                        end
                    end
                end
            end
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s row%0d timeout got none want row scan", name, r);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] want;
        bus.uart_rx = 1'b1;
        bus.roll_ctrl = 2'b00;
        bus.bright_ctrl = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) frame_m[i] = 8'h00;
        #100;
        n_cmp += 5;
        if (bus.row_sel !== 8'h00) begin
            n_err++; $display("FAIL reset row_sel got %02h want 00", bus.row_sel);
        end
        if ((bus.col_r | bus.col_g | bus.col_b) !== 8'h00) begin
            n_err++; $display("FAIL reset cols got %02h want 00", bus.col_r | bus.col_g | bus.col_b);
        end
        if (bus.uart_tx !== 1'b1) begin
            n_err++; $display("FAIL reset uart_tx got %b want 1", bus.uart_tx);
        end
        if (bus.bright_state !== 2'b11) begin
            n_err++; $display("FAIL reset bright_state got %0d want 3", bus.bright_state);
        end
        if (bus.led_state !== 2'b00) begin
            n_err++; $display("FAIL reset led_state got %0d want 0", bus.led_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 8; k++) begin
            want = 8'(1 << (k % 8));
            n_cmp += 2;
            if (bus.row_sel !== want) begin
                n_err++; $display("FAIL row_scan step%0d got %02h want %02h", k, bus.row_sel, want);
            end
            if ($isunknown({bus.row_sel, bus.col_r, bus.col_g, bus.col_b, bus.uart_tx,
                            bus.bright_state, bus.led_state})) begin
                n_err++; $display("FAIL no_x step%0d got X want known", k);
            end
            repeat (ROW) @(negedge clk);
        end
    endtask

    task automatic test_frame_load();
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
            b = 8'h00;
            if (i >= 16 && i <= 21) b = 8'hE0;
            if (i == 9 || i == 12) b = 8'h1C;
            if (i == 50 || i == 51) b = 8'h03;
            send_good(b);
        end
        check_echo("heart");
        check_rows("heart");
    endtask

    task automatic test_framing_error();
        bus.uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        send_byte(8'($urandom_range(1, 255)), 1'b0);
        send_good(8'($urandom_range(1, 255)));
        check_echo("framing");
        check_rows("framing");
    endtask

    task automatic test_brightness();
        int want, cnt;
        bit ok;
        bus.bright_ctrl = 1'b0;
        repeat (DEB / 4) @(negedge clk);
        bus.bright_ctrl = 1'b1;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (bus.bright_state !== 2'd3) begin
            n_err++; $display("FAIL bounce bright_state got %0d want 3", bus.bright_state);
        end
        for (int k = 0; k < 4; k++) begin
            want = k;
            bus.bright_ctrl = 1'b0;
            repeat (100) @(negedge clk);
            bus.bright_ctrl = 1'b1;
            repeat (100) @(negedge clk);
            n_cmp++;
            if (bus.bright_state !== 2'(want)) begin
                n_err++; $display("FAIL press%0d bright_state got %0d want %0d", k,
                                  bus.bright_state, want);
            end
            wait_row(2, ok);
            cnt = 0;
            for (int i = 0; i < int'(ROW); i++) begin
                if (bus.row_sel === 8'h04 && (bus.col_r | bus.col_g | bus.col_b) !== 8'h00) cnt++;
                @(negedge clk);
            end
            n_cmp++;
            if (cnt !== (want + 1) * int'(ROW) / 4 - 8) begin
                n_err++; $display("FAIL level%0d active_cycles got %0d want %0d", want, cnt,
                                  (want + 1) * int'(ROW) / 4 - 8);
            end
        end
    endtask

    task automatic test_scroll();
        bus.roll_ctrl = 2'b10;
        repeat (5 * SCR + 50) @(negedge clk);
        n_cmp++;
        if (bus.led_state !== 2'b10) begin
            n_err++; $display("FAIL left led_state got %0d want 2", bus.led_state);
        end
        check_rows("scroll_left");
        bus.roll_ctrl = 2'b01;
        repeat (3 * SCR) @(negedge clk);
        n_cmp++;
        if (bus.led_state !== 2'b01) begin
            n_err++; $display("FAIL right led_state got %0d want 1", bus.led_state);
        end
        check_rows("scroll_right");
        bus.roll_ctrl = 2'b11;
        repeat (SCR) @(negedge clk);
        n_cmp++;
        if (bus.led_state !== 2'b00) begin
            n_err++; $display("FAIL mode3 led_state got %0d want 0", bus.led_state);
        end
        check_rows("scroll_hold");
    endtask

    task automatic test_random_frame();
        bus.roll_ctrl = 2'b00;
        for (int i = 0; i < 64; i++) send_good(8'($urandom));
        check_echo("random");
        check_rows("random");
    endtask

    initial begin
        test_reset();
        test_frame_load();
        test_framing_error();
        test_brightness();
        test_scroll();
        test_random_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
